// File: rtl/bullet_engine_pkg.sv
`default_nettype none
// ============================================================================
// bullet_engine_pkg: shared direction codes, playfield defaults, bullet FSM
// states and coordinate helpers for the bullet engine.  rev 1.0
// ============================================================================
package bullet_engine_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int SCREEN_W_DEF  = 160;
  localparam int SCREEN_H_DEF  = 120;
  localparam int TANK_SIZE_DEF = 5;

  localparam int NB = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_COOL = 2'd2
  } bstate_e;

  // Wide enough to hold tank coords plus offsets and go negative without wrap.
  typedef logic signed [10:0] coord_t;

  function automatic coord_t ext_x(input logic [XW-1:0] v);
    return coord_t'({3'b000, v});
  endfunction

  function automatic coord_t ext_y(input logic [YW-1:0] v);
    return coord_t'({4'b0000, v});
  endfunction

  function automatic logic on_screen(input coord_t x, input coord_t y,
                                     input int w, input int h);
    return (x >= 0) && (x < coord_t'(w)) && (y >= 0) && (y < coord_t'(h));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_engine_bullet_unit.sv
`default_nettype none
// ============================================================================
// bullet_unit: one bullet -- FSM, position, latched direction, cooldown
// counter and per-tank overlap vector.  rev 1.0
// ============================================================================
module bullet_unit
  import bullet_engine_pkg::*;
#(
  parameter int IDX       = 0,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int TANK_SIZE = TANK_SIZE_DEF,
  parameter int STEP      = 1,
  parameter int COOLDOWN  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  input  logic                  fire_i,
  input  logic [1:0]            dir_i,
  input  logic [NB-1:0][XW-1:0] tx_i,
  input  logic [NB-1:0][YW-1:0] ty_i,
  input  logic [NB-1:0]         te_i,
  output logic [XW-1:0]         bx_o,
  output logic [YW-1:0]         by_o,
  output logic                  be_o,
  output logic [NB-1:0]         overlap_o
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] C_COOL_LOAD = CW'(COOLDOWN);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  bstate_e         state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [1:0]      dir_q, dir_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  coord_t          w_ox, w_oy, w_mx, w_my;
  coord_t          w_bx, w_by, w_nx, w_ny;
  logic            w_spawn, w_move_ok, w_kill;
  logic [NB-1:0]   w_ovl, w_ovl_other;

  // Muzzle point of the owning tank, move target and overlap tests.
  always_comb begin
    w_ox = ext_x(tx_i[IDX]);
    w_oy = ext_y(ty_i[IDX]);
    w_mx = w_ox + coord_t'(2);
    w_my = w_oy + coord_t'(2);
    case (dir_i)
      DIR_UP:    w_my = w_oy - coord_t'(1);
      DIR_RIGHT: w_mx = w_ox + coord_t'(TANK_SIZE);
      DIR_DOWN:  w_my = w_oy + coord_t'(TANK_SIZE);
      default:   w_mx = w_ox - coord_t'(1);
    endcase
    w_spawn = fire_i && te_i[IDX] && on_screen(w_mx, w_my, SCREEN_W, SCREEN_H);

    w_bx = ext_x(x_q);
    w_by = ext_y(y_q);
    w_nx = w_bx;
    w_ny = w_by;
    case (dir_q)
      DIR_UP:    w_ny = w_by - coord_t'(STEP);
      DIR_RIGHT: w_nx = w_bx + coord_t'(STEP);
      DIR_DOWN:  w_ny = w_by + coord_t'(STEP);
      default:   w_nx = w_bx - coord_t'(STEP);
    endcase
    w_move_ok = on_screen(w_nx, w_ny, SCREEN_W, SCREEN_H);

    w_ovl = '0;
    for (int j = 0; j < NB; j++) begin
      w_ovl[j] = te_i[j]
        && (w_bx >= ext_x(tx_i[j])) && (w_bx <= ext_x(tx_i[j]) + coord_t'(TANK_SIZE - 1))
        && (w_by >= ext_y(ty_i[j])) && (w_by <= ext_y(ty_i[j]) + coord_t'(TANK_SIZE - 1));
    end
    w_ovl_other      = w_ovl;
    w_ovl_other[IDX] = 1'b0;
    // Collision wins over the tick: a colliding bullet dies without moving.
    w_kill = (|w_ovl_other) || (tick_i && !w_move_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_spawn) state_d = ST_FLY;
      ST_FLY:  if (w_kill)  state_d = ST_COOL;
      ST_COOL: if ((cnt_q == '0) || (tick_i && (cnt_q == C_ONE))) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_spawn) begin
          x_d   = w_mx[XW-1:0];
          y_d   = w_my[YW-1:0];
          dir_d = dir_i;
        end
      end
      ST_FLY: begin
        if (w_kill) begin
          cnt_d = C_COOL_LOAD;
        end else if (tick_i) begin
          x_d = w_nx[XW-1:0];
          y_d = w_ny[YW-1:0];
        end
      end
      ST_COOL: begin
        if (tick_i && (cnt_q != '0)) cnt_d = cnt_q - C_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= DIR_UP;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    be_o      = (state_q == ST_FLY);
    bx_o      = x_q;
    by_o      = y_q;
    overlap_o = be_o ? w_ovl : '0;
  end

endmodule
`default_nettype wire

// File: rtl/bullet_engine.sv
`default_nettype none
// ============================================================================
// bullet_engine: four tank bullets with spawn, motion, edge/impact kill and
// registered per-tank hit pulses.  rev 1.0
// ============================================================================
module bullet_engine
  import bullet_engine_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int TANK_SIZE = TANK_SIZE_DEF,
  parameter int STEP      = 1,
  parameter int COOLDOWN  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic [3:0]  fire,
  input  logic [7:0]  t1x,
  input  logic [7:0]  t2x,
  input  logic [7:0]  t3x,
  input  logic [7:0]  t4x,
  input  logic [6:0]  t1y,
  input  logic [6:0]  t2y,
  input  logic [6:0]  t3y,
  input  logic [6:0]  t4y,
  input  logic [1:0]  t1d,
  input  logic [1:0]  t2d,
  input  logic [1:0]  t3d,
  input  logic [1:0]  t4d,
  input  logic        t1e,
  input  logic        t2e,
  input  logic        t3e,
  input  logic        t4e,
  output logic [7:0]  b1x,
  output logic [7:0]  b2x,
  output logic [7:0]  b3x,
  output logic [7:0]  b4x,
  output logic [6:0]  b1y,
  output logic [6:0]  b2y,
  output logic [6:0]  b3y,
  output logic [6:0]  b4y,
  output logic        b1e,
  output logic        b2e,
  output logic        b3e,
  output logic        b4e,
  output logic [3:0]  hit
);

  logic [NB-1:0][XW-1:0] w_tx;
  logic [NB-1:0][YW-1:0] w_ty;
  logic [NB-1:0][1:0]    w_td;
  logic [NB-1:0]         w_te;

  logic [XW-1:0]         w_bx    [NB];
  logic [YW-1:0]         w_by    [NB];
  logic                  w_be    [NB];
  logic [NB-1:0]         w_ovl   [NB];
  logic [NB-1:0]         w_ovl_m [NB];
  logic [NB-1:0]         w_hit_d;
  logic [NB-1:0]         hit_q;

  assign w_tx = {t4x, t3x, t2x, t1x};
  assign w_ty = {t4y, t3y, t2y, t1y};
  assign w_td = {t4d, t3d, t2d, t1d};
  assign w_te = {t4e, t3e, t2e, t1e};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_unit
      bullet_unit #(
        .IDX       (gi),
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .TANK_SIZE (TANK_SIZE),
        .STEP      (STEP),
        .COOLDOWN  (COOLDOWN)
      ) u_bullet (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .tick_i    (tick),
        .fire_i    (fire[gi]),
        .dir_i     (w_td[gi]),
        .tx_i      (w_tx),
        .ty_i      (w_ty),
        .te_i      (w_te),
        .bx_o      (w_bx[gi]),
        .by_o      (w_by[gi]),
        .be_o      (w_be[gi]),
        .overlap_o (w_ovl[gi])
      );
      // A bullet sitting on its own tank never counts as a hit.
      assign w_ovl_m[gi] = w_ovl[gi] & ~(NB'(1) << gi);
    end
  endgenerate

  always_comb begin
    w_hit_d = '0;
    for (int i = 0; i < NB; i++) begin
      w_hit_d = w_hit_d | w_ovl_m[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q <= '0;
    end else begin
      hit_q <= w_hit_d;
    end
  end

  assign hit = hit_q;
  assign b1x = w_bx[0];
  assign b2x = w_bx[1];
  assign b3x = w_bx[2];
  assign b4x = w_bx[3];
  assign b1y = w_by[0];
  assign b2y = w_by[1];
  assign b3y = w_by[2];
  assign b4y = w_by[3];
  assign b1e = w_be[0];
  assign b2e = w_be[1];
  assign b3e = w_be[2];
  assign b4e = w_be[3];

endmodule
`default_nettype wire

// File: tb/tb_bullet_engine.sv
`default_nettype none
// ============================================================================
// tb_bullet_engine: directed scenarios plus random play against a behavioural
// model of the bullet rules.  rev 1.0
// ============================================================================
module tb_bullet_engine;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int TS = 5;
  localparam int ST = 1;
  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] fire = 4'b0;
  logic [7:0] tx [4];
  logic [6:0] ty [4];
  logic [1:0] td [4];
  logic [3:0] te = 4'b0;

  logic [7:0] b1x, b2x, b3x, b4x;
  logic [6:0] b1y, b2y, b3y, b4y;
  logic       b1e, b2e, b3e, b4e;
  logic [3:0] hit;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int         m_x [4];
  int         m_y [4];
  int         m_dir [4];
  int         m_wait [4];
  bit         m_live [4];
  bit         m_cool [4];
  logic [3:0] m_hit;

  bullet_engine dut (
    .clk(clk), .resetn(resetn), .tick(tick), .fire(fire),
    .t1x(tx[0]), .t2x(tx[1]), .t3x(tx[2]), .t4x(tx[3]),
    .t1y(ty[0]), .t2y(ty[1]), .t3y(ty[2]), .t4y(ty[3]),
    .t1d(td[0]), .t2d(td[1]), .t3d(td[2]), .t4d(td[3]),
    .t1e(te[0]), .t2e(te[1]), .t3e(te[2]), .t4e(te[3]),
    .b1x(b1x), .b2x(b2x), .b3x(b3x), .b4x(b4x),
    .b1y(b1y), .b2y(b2y), .b3y(b3y), .b4y(b4y),
    .b1e(b1e), .b2e(b2e), .b3e(b3e), .b4e(b4e),
    .hit(hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_bx(input int i);
    case (i)
      0: return b1x;
      1: return b2x;
      2: return b3x;
      default: return b4x;
    endcase
  endfunction

  function automatic logic [6:0] get_by(input int i);
    case (i)
      0: return b1y;
      1: return b2y;
      2: return b3y;
      default: return b4y;
    endcase
  endfunction

  function automatic logic get_be(input int i);
    case (i)
      0: return b1e;
      1: return b2e;
      2: return b3e;
      default: return b4e;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_wait[i] = 0;
      m_live[i] = 0; m_cool[i] = 0;
    end
    m_hit = 4'b0;
  endtask

  function automatic bit inside_tank(input int x, input int y, input int j);
    return te[j] && (x >= int'(tx[j])) && (x <= int'(tx[j]) + TS - 1)
                 && (y >= int'(ty[j])) && (y <= int'(ty[j]) + TS - 1);
  endfunction

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic model_step(input logic [3:0] f, input logic t);
    int nx, ny, mx, my;
    bit coll;
    m_hit = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_live[i]) begin
        coll = 0;
        for (int j = 0; j < 4; j++) begin
          if (j != i && inside_tank(m_x[i], m_y[i], j)) begin
            coll = 1;
            m_hit[j] = 1'b1;
          end
        end
        if (coll) begin
          m_live[i] = 0; m_cool[i] = 1; m_wait[i] = CD;
        end else if (t) begin
          nx = m_x[i] + ((m_dir[i] == 1) ? ST : (m_dir[i] == 3) ? -ST : 0);
          ny = m_y[i] + ((m_dir[i] == 2) ? ST : (m_dir[i] == 0) ? -ST : 0);
          if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
            m_live[i] = 0; m_cool[i] = 1; m_wait[i] = CD;
          end else begin
            m_x[i] = nx; m_y[i] = ny;
          end
        end
      end else if (m_cool[i]) begin
        if (m_wait[i] == 0) m_cool[i] = 0;
        else if (t) begin
          m_wait[i]--;
          if (m_wait[i] == 0) m_cool[i] = 0;
        end
      end else if (f[i] && te[i]) begin
        case (td[i])
          2'd0:    begin mx = int'(tx[i]) + 2;  my = int'(ty[i]) - 1;  end
          2'd1:    begin mx = int'(tx[i]) + TS; my = int'(ty[i]) + 2;  end
          2'd2:    begin mx = int'(tx[i]) + 2;  my = int'(ty[i]) + TS; end
          default: begin mx = int'(tx[i]) - 1;  my = int'(ty[i]) + 2;  end
        endcase
        if (mx >= 0 && mx < W && my >= 0 && my < H) begin
          m_live[i] = 1; m_x[i] = mx; m_y[i] = my; m_dir[i] = int'(td[i]);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("b%0de", i + 1), 32'(get_be(i)), 32'(m_live[i]));
      check_val($sformatf("b%0dx", i + 1), 32'(get_bx(i)), 32'(m_x[i]));
      check_val($sformatf("b%0dy", i + 1), 32'(get_by(i)), 32'(m_y[i]));
    end
    check_val("hit", 32'(hit), 32'(m_hit));
  endtask

  task automatic step(input logic [3:0] f, input logic t);
    fire = f;
    tick = t;
    model_step(f, t);
    @(posedge clk);
    #1;
    fire = 4'b0;
    tick = 1'b0;
    compare_all();
  endtask

  task automatic set_tank(input int i, input int x, input int y, input int d, input bit e);
    tx[i] = 8'(x);
    ty[i] = 7'(y);
    td[i] = 2'(d);
    te[i] = e;
  endtask

  initial begin
    logic [3:0] rf;
    logic       rt;
    for (int i = 0; i < 4; i++) set_tank(i, 100, 100, 0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check_val("reset_hit", 32'(hit), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Spawn to the right, then three moves.
    set_tank(0, 20, 30, 1, 1'b1);
    step(4'b0001, 1'b0);
    check_val("spawn_b1e", 32'(b1e), 32'd1);
    check_val("spawn_b1x", 32'(b1x), 32'd25);
    check_val("spawn_b1y", 32'(b1y), 32'd32);
    repeat (3) step(4'b0000, 1'b1);
    check_val("move3_b1x", 32'(b1x), 32'd28);

    // Run to the right edge; the tick past 159 kills and holds x.
    repeat (131) step(4'b0000, 1'b1);
    check_val("redge_x", 32'(b1x), 32'd159);
    check_val("redge_e", 32'(b1e), 32'd1);
    step(4'b0000, 1'b1);
    check_val("redge_kill_e", 32'(b1e), 32'd0);
    check_val("redge_hold_x", 32'(b1x), 32'd159);

    // Cooldown: fire ignored during ticks 1..7, respawn after the 8th.
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 1'b1);
      check_val("cool_ignore_e", 32'(b1e), 32'd0);
    end
    step(4'b0000, 1'b1);
    set_tank(2, 30, 28, 0, 1'b1);
    step(4'b0001, 1'b0);
    check_val("cool_respawn_e", 32'(b1e), 32'd1);

    // Hit on tank 3.
    repeat (5) step(4'b0000, 1'b1);
    check_val("hit_pre_x", 32'(b1x), 32'd30);
    check_val("hit_pre_e", 32'(b1e), 32'd1);
    check_val("hit_pre_hit", 32'(hit), 32'd0);
    step(4'b0000, 1'b0);
    check_val("hit_e", 32'(b1e), 32'd0);
    check_val("hit_pulse", 32'(hit), 32'b0100);
    step(4'b0000, 1'b0);
    check_val("hit_clear", 32'(hit), 32'd0);

    // Left edge: off-screen muzzle ignored, x=0 spawn killed on first tick.
    set_tank(1, 0, 50, 3, 1'b1);
    step(4'b0010, 1'b0);
    check_val("ledge_nospawn", 32'(b2e), 32'd0);
    set_tank(1, 1, 50, 3, 1'b1);
    step(4'b0010, 1'b0);
    check_val("ledge_spawn_e", 32'(b2e), 32'd1);
    check_val("ledge_spawn_x", 32'(b2x), 32'd0);
    check_val("ledge_spawn_y", 32'(b2y), 32'd52);
    step(4'b0000, 1'b1);
    check_val("ledge_kill_e", 32'(b2e), 32'd0);
    check_val("ledge_hold_x", 32'(b2x), 32'd0);

    // Two bullets enter tank 4 together; spawn with a same-cycle tick.
    repeat (10) step(4'b0000, 1'b1);
    set_tank(2, 30, 28, 0, 1'b0);
    set_tank(3, 60, 60, 0, 1'b1);
    set_tank(0, 50, 62, 1, 1'b1);
    set_tank(1, 70, 62, 3, 1'b1);
    step(4'b0011, 1'b1);
    check_val("sim_spawn_b1x", 32'(b1x), 32'd55);
    check_val("sim_spawn_b2x", 32'(b2x), 32'd69);
    repeat (5) step(4'b0000, 1'b1);
    check_val("sim_b1x", 32'(b1x), 32'd60);
    check_val("sim_b2x", 32'(b2x), 32'd64);
    step(4'b0000, 1'b0);
    check_val("sim_b1e", 32'(b1e), 32'd0);
    check_val("sim_b2e", 32'(b2e), 32'd0);
    check_val("sim_hit", 32'(hit), 32'b1000);
    step(4'b0000, 1'b0);
    check_val("sim_hit_clear", 32'(hit), 32'd0);

    // Async reset with a collision pending.
    repeat (10) step(4'b0000, 1'b1);
    set_tank(1, 70, 62, 3, 1'b0);
    set_tank(3, 60, 60, 0, 1'b0);
    set_tank(2, 30, 28, 0, 1'b1);
    set_tank(0, 20, 30, 1, 1'b1);
    step(4'b0001, 1'b0);
    repeat (5) step(4'b0000, 1'b1);
    check_val("rst_pre_e", 32'(b1e), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_async_e", 32'(b1e), 32'd0);
    check_val("rst_async_x", 32'(b1x), 32'd0);
    check_val("rst_async_y", 32'(b1y), 32'd0);
    check_val("rst_async_hit", 32'(hit), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
    step(4'b0000, 1'b0);
    check_val("rst_no_hit", 32'(hit), 32'd0);

    // Random play.
    for (int n = 0; n < 3000; n++) begin
      if (n % 16 == 0) begin
        for (int i = 0; i < 4; i++) begin
          set_tank(i,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60)),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 45)),
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) != 0));
        end
      end
      for (int b = 0; b < 4; b++) rf[b] = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 2) == 0);
      step(rf, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
